// File: rtl/fmul_pkg.sv
// Binary32 field layout, IEEE exponent constants and response-flag positions
// shared by the FMUL scheduler, its response FIFOs and the requester interface.
package fmul_pkg;
    localparam int exp_max  = 255;
    localparam int exp_bias = 127;

    localparam int F32_W    = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int EXP_W    = 8;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_LSB = 0;
    localparam int FRAC_W   = 23;

    localparam int FLAG_ERR = 1;
    localparam int FLAG_OVF = 0;
    localparam int FLAG_W   = 2;
    localparam int RSP_W    = F32_W + FLAG_W;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } f32_t;

    typedef struct packed {
        f32_t              val;
        logic [FLAG_W-1:0] flags;
    } rsp_t;
endpackage

// File: rtl/fmul_scheduler_if.sv
// Requester, FMUL and response signals of the shared-FMUL scheduler.
// master = requesters plus FMUL datapath, slave = the scheduler itself.
interface fmul_scheduler_if #(parameter int N_REQ = 4);
    import fmul_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [F32_W*N_REQ-1:0]  req_a;
    logic [F32_W*N_REQ-1:0]  req_b;

    logic                    mul_a_sign;
    logic [EXP_W-1:0]        mul_a_exp;
    logic [FRAC_W-1:0]       mul_a_frac;
    logic                    mul_b_sign;
    logic [EXP_W-1:0]        mul_b_exp;
    logic [FRAC_W-1:0]       mul_b_frac;
    logic                    mul_issue;

    logic                    mul_sign;
    logic [EXP_W-1:0]        mul_exp;
    logic [FRAC_W:0]         mul_frac;
    logic                    mul_error;
    logic                    mul_overflow;

    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [F32_W*N_REQ-1:0]  rsp_data;
    logic [FLAG_W*N_REQ-1:0] rsp_flags;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready,
        input  mul_a_sign, mul_a_exp, mul_a_frac, mul_b_sign, mul_b_exp, mul_b_frac, mul_issue,
        output mul_sign, mul_exp, mul_frac, mul_error, mul_overflow,
        input  rsp_valid, rsp_data, rsp_flags,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready,
        output mul_a_sign, mul_a_exp, mul_a_frac, mul_b_sign, mul_b_exp, mul_b_frac, mul_issue,
        input  mul_sign, mul_exp, mul_frac, mul_error, mul_overflow,
        output rsp_valid, rsp_data, rsp_flags,
        input  rsp_ready
    );
endinterface

// File: rtl/fmul_rsp_fifo.sv
// Per-requester result buffer: DEPTH-entry synchronous FIFO, no bypass (push visible next cycle).
// Push into full is dropped; upstream credits keep that from ever happening.
module fmul_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CW'(DEPTH));
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? bump(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

// File: rtl/fmul_scheduler.sv
// Round-robin share of one LAT-cycle FMUL among N_REQ requesters; grant is same-cycle, result visible at t+LAT+1.
// Credit-based admission: a requester is held off (req_ready=0) while its response slots are all committed.
module fmul_scheduler
    import fmul_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int LAT       = 2,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    fmul_scheduler_if.slave   bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CRW = $clog2(RSP_DEPTH + 1);

    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CRW-1:0]         credit_q [N_REQ];
    logic [CRW-1:0]         credit_d [N_REQ];
    logic                   tag_vld_q [LAT];
    logic [IDW-1:0]         tag_id_q  [LAT];

    logic [N_REQ-1:0]       eligible;
    logic                   grant;
    logic [IDW-1:0]         winner;
    logic [N_REQ-1:0]       gnt_oh;
    logic [N_REQ-1:0]       push, pop, fifo_empty, fifo_full;
    logic [N_REQ-1:0]       rsp_valid_v;
    logic [F32_W*N_REQ-1:0] rsp_data_v;
    logic [FLAG_W*N_REQ-1:0] rsp_flags_v;
    f32_t                   op_a, op_b;
    rsp_t                   rsp_in;
    rsp_t                   rsp_head [N_REQ];
    logic                   unused_frac_msb;
    int                     idx;

    // Folding rst into eligibility keeps req_ready and mul_issue low during reset.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = !rst && bus.req_valid[i] && (credit_q[i] != '0);
        end
    end

    always_comb begin
        grant  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant && eligible[idx]) begin
                grant  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (grant) begin
            gnt_oh[winner] = 1'b1;
        end
    end

    assign bus.req_ready  = gnt_oh;
    assign bus.mul_issue  = grant;
    assign op_a           = bus.req_a[F32_W*winner +: F32_W];
    assign op_b           = bus.req_b[F32_W*winner +: F32_W];
    assign bus.mul_a_sign = op_a.sign;
    assign bus.mul_a_exp  = op_a.exp;
    assign bus.mul_a_frac = op_a.frac;
    assign bus.mul_b_sign = op_b.sign;
    assign bus.mul_b_exp  = op_b.exp;
    assign bus.mul_b_frac = op_b.frac;

    assign rr_ptr_d = !grant ? rr_ptr_q :
                      (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;

    // The FMUL hidden bit is implied by the exponent, so only frac[22:0] is kept.
    assign unused_frac_msb = bus.mul_frac[FRAC_W];

    always_comb begin
        rsp_in                 = '0;
        rsp_in.val.sign        = bus.mul_sign;
        rsp_in.val.exp         = bus.mul_exp;
        rsp_in.val.frac        = bus.mul_frac[FRAC_W-1:0];
        rsp_in.flags[FLAG_ERR] = bus.mul_error;
        rsp_in.flags[FLAG_OVF] = bus.mul_overflow;
        for (int i = 0; i < N_REQ; i++) begin
            push[i] = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == IDW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_v[i]                 = !fifo_empty[i] && !rst;
            rsp_data_v[F32_W*i +: F32_W]   = rsp_valid_v[i] ? rsp_head[i].val   : '0;
            rsp_flags_v[FLAG_W*i +: FLAG_W] = rsp_valid_v[i] ? rsp_head[i].flags : '0;
            pop[i]                         = rsp_valid_v[i] && bus.rsp_ready[i];
            credit_d[i]                    = credit_q[i];
            if (gnt_oh[i] && !pop[i]) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end else if (pop[i] && !gnt_oh[i]) begin
                credit_d[i] = credit_q[i] + 1'b1;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_v;
    assign bus.rsp_data  = rsp_data_v;
    assign bus.rsp_flags = rsp_flags_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                credit_q[i] <= CRW'(RSP_DEPTH);
            end
            for (int s = 0; s < LAT; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_id_q[s]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < N_REQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
            tag_vld_q[0] <= grant;
            tag_id_q[0]  <= winner;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_rsp
        fmul_rsp_fifo #(
            .DEPTH (RSP_DEPTH),
            .WIDTH (RSP_W)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (push[g]),
            .push_dat_i (rsp_in),
            .pop_i      (pop[g]),
            .head_dat_o (rsp_head[g]),
            .empty_o    (fifo_empty[g]),
            .full_o     (fifo_full[g])
        );
    end

    // A retire into a full buffer means the credit accounting is broken.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) (push & fifo_full) == '0);
endmodule

// File: tb/tb_fmul_scheduler.sv
// Scoreboard bench: a behavioural FMUL feeds the scheduler; a monitor predicts grants,
// credits and per-requester response order from queues and checks every cycle.
module tb_fmul_scheduler;
    import fmul_pkg::*;

    localparam int N_REQ     = 4;
    localparam int LAT       = 2;
    localparam int RSP_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmul_scheduler_if #(.N_REQ(N_REQ)) bus ();

    fmul_scheduler #(
        .N_REQ     (N_REQ),
        .LAT       (LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  flg;
        logic [31:0] vis;
    } exp_t;

    exp_t        sb [N_REQ][$];
    int          rr_model = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          m_win;
    int          m_idx;
    logic        m_expv;
    logic [34:0] m_res;
    exp_t        m_e;
    logic [34:0] fpipe [LAT];

    // Result fields {sign, exp, frac24, error, overflow}; denormals flush to zero, truncating.
    function automatic logic [34:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0] p;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        a_nan  = (ea == 8'(exp_max)) && (fa != 0);
        b_nan  = (eb == 8'(exp_max)) && (fb != 0);
        a_inf  = (ea == 8'(exp_max)) && (fa == 0);
        b_inf  = (eb == 8'(exp_max)) && (fb == 0);
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            return {1'b0, 8'hFF, 24'hC00000, 2'b10};
        if (a_inf || b_inf)
            return {s, 8'hFF, 24'h000000, 2'b00};
        if (a_zero || b_zero)
            return {s, 8'h00, 24'h000000, 2'b00};
        p = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
        e = int'(ea) + int'(eb) - exp_bias;
        if (p[47]) begin
            e = e + 1;
            p = p >> 1;
        end
        if (e >= exp_max)
            return {s, 8'hFF, 24'h000000, 2'b01};
        if (e <= 0)
            return {s, 8'h00, 24'h000000, 2'b00};
        return {s, e[7:0], p[46:23], 2'b00};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 9))
            0:       return 32'h7F800000;
            1:       return 32'h00000000;
            2:       return 32'h7FC00001;
            3:       return {1'($urandom), 8'hFE, 23'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FMUL: garbage on idle slots so the scheduler must rely on its own tags.
    always @(posedge clk) begin
        fpipe[0] <= bus.mul_issue ?
                    fmul_ref({bus.mul_a_sign, bus.mul_a_exp, bus.mul_a_frac},
                             {bus.mul_b_sign, bus.mul_b_exp, bus.mul_b_frac}) :
                    {$urandom, 3'($urandom)};
        for (int s = 1; s < LAT; s++) fpipe[s] <= fpipe[s-1];
    end

    assign bus.mul_sign     = fpipe[LAT-1][34];
    assign bus.mul_exp      = fpipe[LAT-1][33:26];
    assign bus.mul_frac     = fpipe[LAT-1][25:2];
    assign bus.mul_error    = fpipe[LAT-1][1];
    assign bus.mul_overflow = fpipe[LAT-1][0];

    // Monitor / scoreboard
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_mul_issue", bus.mul_issue, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_data",  bus.rsp_data[63:0], 0);
            chk("rst_rsp_data_hi", bus.rsp_data[127:64], 0);
            chk("rst_rsp_flags", bus.rsp_flags, 0);
            for (int i = 0; i < N_REQ; i++) sb[i].delete();
            rr_model = 0;
        end else begin
            m_win = -1;
            for (int k = 0; k < N_REQ; k++) begin
                m_idx = (rr_model + k) % N_REQ;
                if (m_win < 0 && bus.req_valid[m_idx] && sb[m_idx].size() < RSP_DEPTH)
                    m_win = m_idx;
            end
            chk("req_ready", bus.req_ready, (m_win >= 0) ? (64'd1 << m_win) : 64'd0);
            chk("mul_issue", bus.mul_issue, (m_win >= 0) ? 64'd1 : 64'd0);
            if (m_win >= 0) begin
                chk("mul_a_fields", {bus.mul_a_sign, bus.mul_a_exp, bus.mul_a_frac}, bus.req_a[32*m_win +: 32]);
                chk("mul_b_fields", {bus.mul_b_sign, bus.mul_b_exp, bus.mul_b_frac}, bus.req_b[32*m_win +: 32]);
                m_res = fmul_ref(bus.req_a[32*m_win +: 32], bus.req_b[32*m_win +: 32]);
                m_e.dat = {m_res[34], m_res[33:26], m_res[24:2]};
                m_e.flg = m_res[1:0];
                m_e.vis = 32'(cyc + LAT + 1);
                sb[m_win].push_back(m_e);
                rr_model = (m_win + 1) % N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                m_expv = (sb[i].size() > 0) && (int'(sb[i][0].vis) <= cyc);
                chk($sformatf("rsp_valid[%0d]", i), bus.rsp_valid[i], m_expv);
                if (m_expv) begin
                    chk($sformatf("rsp_data[%0d]", i), bus.rsp_data[32*i +: 32], sb[i][0].dat);
                    chk($sformatf("rsp_flags[%0d]", i), bus.rsp_flags[2*i +: 2], sb[i][0].flg);
                    if (bus.rsp_ready[i]) void'(sb[i].pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    int g1, gothers, cnt;

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single multiply: 1.0 * 2.0 from requester 0
        set_op(0, 32'h3F800000, 32'h40000000);
        bus.req_valid = 4'b0001;
        #1 chk("single_grant", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("single_rsp_valid", bus.rsp_valid[0], 1);
        chk("single_rsp_data",  bus.rsp_data[31:0], 32'h40000000);
        chk("single_rsp_flags", bus.rsp_flags[1:0], 2'b00);

        // Round-robin from reset
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_op(i, rand_op(), rand_op());
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_grant", bus.req_ready, 64'd1 << (k % 4));
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) set_op(i, rand_op(), rand_op());
        end
        bus.req_valid = '0;
        repeat (6) @(negedge clk);

        // Backpressure on requester 1
        do_reset();
        bus.rsp_ready = 4'b1101;
        bus.req_valid = '1;
        g1 = 0;
        gothers = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (bus.req_ready[1]) g1++;
            if ((bus.req_ready & 4'b1101) != 0) gothers++;
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) set_op(i, rand_op(), rand_op());
        end
        chk("bp_req1_grants", g1, 2);
        chk("bp_others_grants", gothers, 14);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 4'b0010;
        #1;
        chk("bp_pop_valid", bus.rsp_valid[1], 1);
        chk("bp_no_grant_at_pop", bus.req_ready, 0);
        @(negedge clk);
        bus.rsp_ready = 4'b0000;
        #1 chk("bp_regrant", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (8) @(negedge clk);

        // Exception passthrough behind a normal result on requester 2
        set_op(2, 32'h3FC00000, 32'h40400000);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        set_op(2, 32'h7F800000, 32'h00000000);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("exc_rsp_valid", bus.rsp_valid[2], 1);
        chk("exc_rsp_data",  bus.rsp_data[95:64], 32'h7FC00000);
        chk("exc_rsp_flags", bus.rsp_flags[5:4], 2'b10);
        repeat (4) @(negedge clk);

        // Reset with two operations in flight
        set_op(0, rand_op(), rand_op());
        set_op(1, rand_op(), rand_op());
        bus.req_valid = 4'b0011;
        repeat (2) @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            #1 if (bus.rsp_valid != 0) cnt++;
            @(negedge clk);
        end
        chk("rst_flush_no_rsp", cnt, 0);
        set_op(0, 32'h3F800000, 32'h40000000);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 4'b1110;
        g1 = 0;
        for (int k = 0; k < 5; k++) begin
            #1 if (bus.req_ready[0]) g1++;
            @(negedge clk);
        end
        chk("rst_credits_restored", g1, RSP_DEPTH);
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (4) @(negedge clk);

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 1500; n++) begin
            rst           = (n % 500 == 499);
            bus.req_valid = 4'($urandom);
            for (int i = 0; i < N_REQ; i++) begin
                bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
                set_op(i, rand_op(), rand_op());
            end
            @(negedge clk);
        end
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (10) @(negedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) chk($sformatf("drain_empty[%0d]", i), sb[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
